pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter STAGES, default 3, number of pipeline register stages (>=1).
REQ-003 SHALL have parameter SIGNED, default 0: 1 = two's-complement operands, 0 = unsigned.
REQ-004 SHALL have parameter SAT, default 0: 1 = saturate on overflow, 0 = wrap.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  operands valid.
REQ-009 in_ready  output  1  block accepts operands this cycle.
REQ-010 in1  input  WIDTH  first operand.
REQ-011 in2  input  WIDTH  second operand.
REQ-012 op  input  1  0 = ADD, 1 = SUB (in1 - in2).
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out  output  WIDTH  result.
REQ-016 carry  output  1  ADD: carry-out; SUB: borrow (in1 < in2 unsigned).
REQ-017 overflow  output  1  result not representable in WIDTH under SIGNED mode.
REQ-018 txn_count  output  16  completed output handshakes.

Function
REQ-019 Input handshake SHALL occur when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-020 Result, carry and overflow SHALL be computed combinationally from the accepted operands and captured into stage 1; stages 2..STAGES SHALL only delay them.
REQ-021 Latency SHALL be exactly STAGES cycles from input handshake to out_valid when out_ready stays 1; throughput one result per cycle.
REQ-022 Each stage k SHALL load when !valid_k || ready_{k+1} (ready_{STAGES+1} = out_ready); in_ready SHALL equal stage-1 load condition (bubbles collapse).
REQ-023 While out_valid && !out_ready, out/carry/overflow SHALL remain stable and no result SHALL be lost or duplicated.
REQ-024 Arithmetic SHALL use a WIDTH+1-bit internal sum; unsigned overflow = carry (ADD) or borrow (SUB); signed overflow = operand-sign/result-sign rule.
REQ-025 SAT=1: on overflow out SHALL clamp to max/min of the SIGNED range (unsigned SUB underflow -> 0); overflow flag still asserted.
REQ-026 SAT=0: out SHALL be the low WIDTH bits of the sum.
REQ-027 txn_count SHALL increment by 1 per output handshake and wrap 0xFFFF -> 0x0000.
REQ-028 Simultaneous input and output handshake on a full pipeline SHALL be accepted in the same cycle.

Reset
REQ-029 While reset=1, all stage valid bits, out_valid, out, carry, overflow and txn_count SHALL be 0 at the next edge.
REQ-030 in_ready SHALL be 0 during reset and 1 in the first cycle after reset deasserts.
REQ-031 Reset mid-operation SHALL discard all in-flight results; none SHALL appear afterwards.

Structure
REQ-032 Shared package adder_pkg SHALL hold the op enum (OP_ADD, OP_SUB) and the result-bundle struct type (out, carry, overflow).
REQ-033 One sub-module pipe_stage (valid/ready register slice for the result bundle) SHALL be instantiated STAGES times via generate.

Verification (WIDTH=8, STAGES=3)
REQ-034 SIGNED=0 ADD 200+100, out_ready=1 -> out=44, carry=1, overflow=1, out_valid exactly 3 cycles after accept.
REQ-035 SIGNED=1 SAT=1 ADD 100+100 -> out=127, overflow=1; SUB (-100)-100 -> out=-128, overflow=1.
REQ-036 SIGNED=0 SUB 5-7, SAT=0 -> out=254, carry=1; SAT=1 -> out=0.
REQ-037 20 back-to-back ADDs with out_ready toggling 1/0 each cycle -> all 20 results in order, none lost, txn_count=20.
REQ-038 Pipeline full, out_ready=0 for 5 cycles -> in_ready=0, out stable; release -> one result per cycle.
REQ-039 Reset pulsed with 2 results in flight -> no out_valid after reset, txn_count=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder: operation select and the result bundle
// carried through the pipeline.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Widest operand the bundle can hold; pipe_adder uses the low WIDTH bits of out.
    localparam int unsigned RES_W_MAX = 128;

    typedef struct packed {
        logic [RES_W_MAX-1:0] out;
        logic                 carry;
        logic                 overflow;
    } res_t;

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register slice. Loads whenever empty or when downstream
// takes the current word, so bubbles collapse.
module pipe_stage #(
    parameter int unsigned DW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          load;

    always_comb begin
        load    = !valid_q || ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = load;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with optional signed interpretation and saturation.
// The result is computed before stage 1; later stages only delay it.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 3,
    parameter bit          SIGNED = 1'b0,
    parameter bit          SAT    = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic [15:0]      txn_count
);

    localparam int unsigned DW = WIDTH + 2;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    op_e            op_sel;
    logic [WIDTH:0] sum;
    logic           s_ovf;
    res_t           res;
    logic [DW-1:0]  res_bus;
    logic [15:0]    txn_q, txn_d;

    assign op_sel = op_e'(op);

    always_comb begin
        if (op_sel == OP_SUB) begin
            sum   = {1'b0, in1} - {1'b0, in2};
            s_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
        end else begin
            sum   = {1'b0, in1} + {1'b0, in2};
            s_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
        end

        res                 = '0;
        res.carry           = sum[WIDTH];
        res.overflow        = SIGNED ? s_ovf : sum[WIDTH];
        res.out[WIDTH-1:0]  = sum[WIDTH-1:0];
        // Signed overflow direction always follows in1's sign.
        if (SAT && res.overflow) begin
            if (SIGNED) begin
                res.out[WIDTH-1:0] = in1[WIDTH-1] ? SMIN : SMAX;
            end else begin
                res.out[WIDTH-1:0] = (op_sel == OP_SUB) ? '0 : '1;
            end
        end
    end

    assign res_bus = {res.out[WIDTH-1:0], res.carry, res.overflow};

    logic unused_hi;
    if (WIDTH < RES_W_MAX) begin : g_hi
        assign unused_hi = |res.out[RES_W_MAX-1:WIDTH];
    end else begin : g_nohi
        assign unused_hi = 1'b0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          up_valid, dn_ready, ld, vld;
        logic [DW-1:0] up_data, dat;

        if (k == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = res_bus;
        end else begin : g_chain
            assign up_valid = g_stage[k-1].vld;
            assign up_data  = g_stage[k-1].dat;
        end

        if (k == STAGES - 1) begin : g_last
            assign dn_ready = out_ready;
        end else begin : g_inner
            assign dn_ready = g_stage[k+1].ld;
        end

        pipe_stage #(.DW(DW)) u_stage (
            .clk_i   (clock),
            .rst_i   (reset),
            .valid_i (up_valid),
            .ready_o (ld),
            .data_i  (up_data),
            .valid_o (vld),
            .ready_i (dn_ready),
            .data_o  (dat)
        );
    end

    assign in_ready  = g_stage[0].ld && !reset;
    assign out_valid = g_stage[STAGES-1].vld;
    assign out       = g_stage[STAGES-1].dat[DW-1:2];
    assign carry     = g_stage[STAGES-1].dat[1];
    assign overflow  = g_stage[STAGES-1].dat[0];

    always_comb begin
        txn_d = txn_q;
        if (out_valid && out_ready) begin
            txn_d = txn_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            txn_q <= '0;
        end else begin
            txn_q <= txn_d;
        end
    end

    assign txn_count = txn_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: three configurations driven with identical stimulus,
// each checked against an integer-arithmetic reference model.
module tb_pipe_adder;

    localparam int W = 8;
    localparam int N = 3;

    typedef struct packed {
        logic [7:0] out;
        logic       c;
        logic       ov;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       op = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in1 = '0;
    logic [7:0] in2 = '0;

    logic       in_ready_w  [N];
    logic       out_valid_w [N];
    logic       carry_w     [N];
    logic       overflow_w  [N];
    logic [7:0] out_w       [N];
    logic [15:0] txn_w      [N];

    exp_t        sb [N][$];
    logic [15:0] exp_cnt [N];
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    // dut0: unsigned wrap, dut1: signed saturate, dut2: unsigned saturate
    for (genvar g = 0; g < N; g++) begin : g_dut
        pipe_adder #(
            .WIDTH  (8),
            .STAGES (3),
            .SIGNED (g == 1),
            .SAT    (g != 0)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .in1       (in1),
            .in2       (in2),
            .op        (op),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out       (out_w[g]),
            .carry     (carry_w[g]),
            .overflow  (overflow_w[g]),
            .txn_count (txn_w[g])
        );
    end

    function automatic bit sgn_of(int i);
        return i == 1;
    endfunction

    function automatic bit sat_of(int i);
        return i != 0;
    endfunction

    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic sub, bit sgn, bit sat);
        int av, bv, r, lo, hi;
        exp_t e;
        av = sgn ? int'($signed(a)) : int'(a);
        bv = sgn ? int'($signed(b)) : int'(b);
        r  = sub ? av - bv : av + bv;
        lo = sgn ? -(2 ** (W - 1)) : 0;
        hi = sgn ? (2 ** (W - 1)) - 1 : (2 ** W) - 1;
        e.c  = sub ? (int'(a) < int'(b)) : ((int'(a) + int'(b)) >= 2 ** W);
        e.ov = (r < lo) || (r > hi);
        if (sat && e.ov) r = (r > hi) ? hi : lo;
        e.out = r[7:0];
        return e;
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    // Samples handshakes just after the input drive, then advances one clock.
    task automatic cycle();
        exp_t e;
        #1;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                sb[i].delete();
                exp_cnt[i] = '0;
            end else begin
                if (in_valid && in_ready_w[i])
                    sb[i].push_back(model(in1, in2, op, sgn_of(i), sat_of(i)));
                if (out_valid_w[i] && out_ready) begin
                    if (sb[i].size() == 0) begin
                        chk("unexpected_result", i, 1, 0);
                    end else begin
                        e = sb[i].pop_front();
                        chk("out", i, 32'(out_w[i]), 32'(e.out));
                        chk("carry", i, 32'(carry_w[i]), 32'(e.c));
                        chk("overflow", i, 32'(overflow_w[i]), 32'(e.ov));
                    end
                    exp_cnt[i] = exp_cnt[i] + 16'd1;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic rand_ops(input bit any_op);
        logic [7:0] edges [5];
        edges = '{8'd0, 8'd255, 8'd127, 8'd128, 8'd1};
        in1 = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 8'($urandom);
        in2 = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 8'($urandom);
        op  = any_op ? 1'($urandom) : 1'b0;
    endtask

    // Issues one operation into an empty pipe and checks the 3-cycle latency;
    // returns with the result presented but not yet consumed.
    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic s);
        in1 = a; in2 = b; op = s; in_valid = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) chk("latency_c1", i, 32'(out_valid_w[i]), 0);
        cycle();
        for (int i = 0; i < N; i++) chk("latency_c2", i, 32'(out_valid_w[i]), 0);
        cycle();
        for (int i = 0; i < N; i++) chk("latency_c3", i, 32'(out_valid_w[i]), 1);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && budget < 20) begin
            cycle();
            budget++;
        end
        for (int i = 0; i < N; i++) chk(tag, i, 32'(sb[i].size()), 0);
    endtask

    initial begin
        int sent, cyc;
        bit acc;
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;

        // Reset state
        reset = 1'b1;
        @(negedge clock);
        cycle();
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_in_ready", i, 32'(in_ready_w[i]), 0);
            chk("rst_out_valid", i, 32'(out_valid_w[i]), 0);
            chk("rst_out", i, 32'(out_w[i]), 0);
            chk("rst_carry", i, 32'(carry_w[i]), 0);
            chk("rst_overflow", i, 32'(overflow_w[i]), 0);
            chk("rst_txn", i, 32'(txn_w[i]), 0);
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) chk("in_ready_after_rst", i, 32'(in_ready_w[i]), 1);

        // Directed arithmetic vectors
        run_one(8'd200, 8'd100, 1'b0);
        chk("add_200_100_out", 0, 32'(out_w[0]), 44);
        chk("add_200_100_c", 0, 32'(carry_w[0]), 1);
        chk("add_200_100_ov", 0, 32'(overflow_w[0]), 1);
        cycle();
        run_one(8'd100, 8'd100, 1'b0);
        chk("sadd_sat_out", 1, 32'(out_w[1]), 127);
        chk("sadd_sat_ov", 1, 32'(overflow_w[1]), 1);
        cycle();
        run_one(8'h9C, 8'd100, 1'b1);
        chk("ssub_sat_out", 1, 32'(out_w[1]), 32'h80);
        chk("ssub_sat_ov", 1, 32'(overflow_w[1]), 1);
        cycle();
        run_one(8'd5, 8'd7, 1'b1);
        chk("usub_wrap_out", 0, 32'(out_w[0]), 254);
        chk("usub_wrap_c", 0, 32'(carry_w[0]), 1);
        chk("usub_sat_out", 2, 32'(out_w[2]), 0);
        chk("usub_sat_ov", 2, 32'(overflow_w[2]), 1);
        cycle();

        // 20 back-to-back ADDs with out_ready toggling
        do_reset();
        sent = 0; cyc = 0;
        out_ready = 1'b0;
        rand_ops(1'b0);
        while ((sent < 20 || (sb[0].size() + sb[1].size() + sb[2].size()) != 0) && cyc < 400) begin
            out_ready = ~out_ready;
            in_valid = (sent < 20);
            #1;
            acc = in_valid && in_ready_w[0];
            cycle();
            if (acc) begin
                sent++;
                rand_ops(1'b0);
            end
            cyc++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("b2b_pending", i, 32'(sb[i].size()), 0);
            chk("b2b_txn", i, 32'(txn_w[i]), 20);
        end

        // Full pipe held by downstream, then released
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_ops(1'b1);
        cyc = 0;
        while (cyc < 10) begin
            #1;
            acc = in_valid && in_ready_w[0];
            cycle();
            if (acc) rand_ops(1'b1);
            cyc++;
        end
        for (int i = 0; i < N; i++) chk("full_depth", i, 32'(sb[i].size()), 3);
        for (int k = 0; k < 5; k++) begin
            #1;
            for (int i = 0; i < N; i++) begin
                chk("stall_in_ready", i, 32'(in_ready_w[i]), 0);
                chk("stall_out_valid", i, 32'(out_valid_w[i]), 1);
                if (sb[i].size() != 0) chk("stall_out_stable", i, 32'(out_w[i]), 32'(sb[i][0].out));
            end
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            for (int i = 0; i < N; i++) begin
                chk("release_out_valid", i, 32'(out_valid_w[i]), 1);
                chk("release_in_ready", i, 32'(in_ready_w[i]), 1);
            end
            cycle();
            rand_ops(1'b1);
        end
        drain("release_drain");

        // Random traffic, mixed ops and backpressure
        do_reset();
        for (int k = 0; k < 300; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_ops(1'b1);
            cycle();
        end
        drain("random_drain");
        for (int i = 0; i < N; i++) chk("random_txn", i, 32'(txn_w[i]), 32'(exp_cnt[i]));

        // Reset with two results in flight
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        rand_ops(1'b1);
        cycle();
        rand_ops(1'b1);
        cycle();
        in_valid = 1'b0;
        reset = 1'b1;
        cycle();
        #1;
        for (int i = 0; i < N; i++) begin
            chk("midrst_in_ready", i, 32'(in_ready_w[i]), 0);
            chk("midrst_out_valid", i, 32'(out_valid_w[i]), 0);
            chk("midrst_out", i, 32'(out_w[i]), 0);
            chk("midrst_txn", i, 32'(txn_w[i]), 0);
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) chk("midrst_ready_after", i, 32'(in_ready_w[i]), 1);
        for (int k = 0; k < 6; k++) begin
            cycle();
            for (int i = 0; i < N; i++) chk("midrst_no_result", i, 32'(out_valid_w[i]), 0);
        end
        for (int i = 0; i < N; i++) chk("midrst_txn_after", i, 32'(txn_w[i]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
